// File: rtl/arm_muldiv.sv
// arm_muldiv: iterative unsigned multiply / divide unit next to the ALU.
// One result bit per cycle: shift-add multiply (LSB first) and restoring
// division (MSB first). Results and {N,Z,C,V} flags are registered and
// change only when the FSM enters DONE.
module arm_muldiv #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    // a: multiplicand (held) or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] a_q, a_d;
    // b: multiplier shifting right, or divisor (held)
    logic [WIDTH-1:0] b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_v;
    logic [WIDTH-1:0]   dz_res;

    // One iteration of each algorithm plus the value to publish on completion
    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        acc_step  = {add_sum, acc_q[WIDTH-1:1]};
        rem_shift = {rem_q, a_q[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, b_q};
        if (rem_trial[WIDTH]) begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {a_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = rem_trial[WIDTH-1:0];
            quo_step = {a_q[WIDTH-2:0], 1'b1};
        end
        fin_v = 1'b0;
        unique case (op_q)
            2'b00: begin
                fin_res = acc_step[WIDTH-1:0];
                fin_v   = |acc_step[2*WIDTH-1:WIDTH];
            end
            2'b01:   fin_res = acc_step[2*WIDTH-1:WIDTH];
            2'b10:   fin_res = quo_step;
            default: fin_res = rem_step;
        endcase
        // divide by zero: quotient all ones, remainder is the dividend
        dz_res = op[0] ? srca : '1;
    end

    // FSM next state and datapath register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        flags_d  = flags_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = srca;
                    b_d   = srcb;
                    cnt_d = CW'(WIDTH);
                    acc_d = '0;
                    rem_d = '0;
                    if (op[1] && (srcb == '0)) begin
                        state_d  = S_DONE;
                        result_d = dz_res;
                        flags_d  = {dz_res[WIDTH-1], (dz_res == '0), 1'b0, 1'b1};
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q[1]) begin
                    a_d   = quo_step;
                    rem_d = rem_step;
                end else begin
                    acc_d = acc_step;
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                    flags_d  = {fin_res[WIDTH-1], (fin_res == '0), 1'b0, fin_v};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset low aborts any operation immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign flags  = flags_q;

endmodule
